// File: rtl/cdb_pkg.sv
// Shared types for the CDB writeback arbiter: widths, source numbering and queue entry layout.
package cdb_pkg;

  localparam int unsigned RB_W = 4;
  localparam int unsigned XLEN = 32;
  localparam int unsigned NSRC = 3;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_BRU = 2'd1,
    SRC_LSB = 2'd2
  } src_e;

  typedef struct packed {
    logic [RB_W-1:0] idx;
    logic [XLEN-1:0] val;
  } wb_entry_t;

  // Distance from the ROB head; wraps naturally so smaller means older.
  function automatic logic [RB_W-1:0] entry_age(input logic [RB_W-1:0] idx,
                                                input logic [RB_W-1:0] front);
    return idx - front;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular queue of writeback entries with flush and a registered not-full flag.
module wb_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  input  logic      flush,
  output logic      not_empty,
  output wb_entry_t head,
  output logic      not_full
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  wb_entry_t       mem [DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            not_full_q, not_full_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
    // Based on the post-update count, so a same-cycle pop never raises ready early.
    not_full_d = (count_d < CntW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      not_full_q <= 1'b1;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      not_full_q <= not_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign not_empty = (count_q != '0);
  assign head      = mem[rd_ptr_q];
  assign not_full  = not_full_q;

endmodule

// File: rtl/cdb_wb_arbiter.sv
// Writeback arbiter: queues results from ALU/BRU/LSB and broadcasts the two oldest heads
// per cycle on two registered CDB ports.
module cdb_wb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic [RB_W-1:0] rob_front,
  input  logic            alu_valid,
  input  logic [RB_W-1:0] alu_idx,
  input  logic [XLEN-1:0] alu_val,
  output logic            alu_ready,
  input  logic            bru_valid,
  input  logic [RB_W-1:0] bru_idx,
  input  logic [XLEN-1:0] bru_val,
  output logic            bru_ready,
  input  logic            lsb_valid,
  input  logic [RB_W-1:0] lsb_idx,
  input  logic [XLEN-1:0] lsb_val,
  output logic            lsb_ready,
  output logic            cdb0_valid,
  output logic [RB_W-1:0] cdb0_idx,
  output logic [XLEN-1:0] cdb0_val,
  output logic            cdb1_valid,
  output logic [RB_W-1:0] cdb1_idx,
  output logic [XLEN-1:0] cdb1_val
);

  logic            active;
  logic [NSRC-1:0] in_valid, q_ready, q_avail, push, pop, take0, take1;
  wb_entry_t       in_data [NSRC];
  wb_entry_t       head [NSRC];
  logic [RB_W-1:0] age [NSRC];
  logic [1:0]      rank [NSRC];
  wb_entry_t       sel0, sel1;

  logic            cdb0_valid_q, cdb0_valid_d, cdb1_valid_q, cdb1_valid_d;
  wb_entry_t       cdb0_q, cdb0_d, cdb1_q, cdb1_d;

  assign active = rdy && !flush;

  assign in_valid[SRC_ALU] = alu_valid;
  assign in_valid[SRC_BRU] = bru_valid;
  assign in_valid[SRC_LSB] = lsb_valid;
  assign in_data[SRC_ALU]  = '{idx: alu_idx, val: alu_val};
  assign in_data[SRC_BRU]  = '{idx: bru_idx, val: bru_val};
  assign in_data[SRC_LSB]  = '{idx: lsb_idx, val: lsb_val};
  assign alu_ready = q_ready[SRC_ALU];
  assign bru_ready = q_ready[SRC_BRU];
  assign lsb_ready = q_ready[SRC_LSB];

  assign push = in_valid & q_ready & {NSRC{active}};
  assign pop  = (take0 | take1) & {NSRC{active}};

  for (genvar g = 0; g < NSRC; g++) begin : g_src
    wb_fifo #(
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push[g]),
      .push_data(in_data[g]),
      .pop      (pop[g]),
      .flush    (flush),
      .not_empty(q_avail[g]),
      .head     (head[g]),
      .not_full (q_ready[g])
    );
  end

  // Rank each valid head by how many other valid heads beat it; ties go to the lower source.
  always_comb begin
    for (int i = 0; i < NSRC; i++) begin
      age[i]  = entry_age(head[i].idx, rob_front);
      rank[i] = 2'd0;
    end
    for (int i = 0; i < NSRC; i++) begin
      for (int j = 0; j < NSRC; j++) begin
        if (j != i && q_avail[j] && (age[j] < age[i] || (age[j] == age[i] && j < i))) begin
          rank[i] = rank[i] + 2'd1;
        end
      end
    end
    take0 = '0;
    take1 = '0;
    sel0  = head[0];
    sel1  = head[0];
    for (int i = 0; i < NSRC; i++) begin
      take0[i] = q_avail[i] && (rank[i] == 2'd0);
      take1[i] = q_avail[i] && (rank[i] == 2'd1);
      if (take0[i]) sel0 = head[i];
      if (take1[i]) sel1 = head[i];
    end
  end

  always_comb begin
    cdb0_valid_d = cdb0_valid_q;
    cdb1_valid_d = cdb1_valid_q;
    cdb0_d       = cdb0_q;
    cdb1_d       = cdb1_q;
    if (flush) begin
      cdb0_valid_d = 1'b0;
      cdb1_valid_d = 1'b0;
    end else if (rdy) begin
      cdb0_valid_d = |take0;
      cdb1_valid_d = |take1;
      // Unused slots keep their last payload; only the valid bit drops.
      if (|take0) cdb0_d = sel0;
      if (|take1) cdb1_d = sel1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb0_valid_q <= 1'b0;
      cdb1_valid_q <= 1'b0;
      cdb0_q       <= '0;
      cdb1_q       <= '0;
    end else begin
      cdb0_valid_q <= cdb0_valid_d;
      cdb1_valid_q <= cdb1_valid_d;
      cdb0_q       <= cdb0_d;
      cdb1_q       <= cdb1_d;
    end
  end

  assign cdb0_valid = cdb0_valid_q;
  assign cdb0_idx   = cdb0_q.idx;
  assign cdb0_val   = cdb0_q.val;
  assign cdb1_valid = cdb1_valid_q;
  assign cdb1_idx   = cdb1_q.idx;
  assign cdb1_val   = cdb1_q.val;

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Self-checking bench for cdb_wb_arbiter: directed scenarios plus random traffic against a
// queue-based age-ordering reference model.
module tb_cdb_wb_arbiter;
  import cdb_pkg::*;

  localparam int unsigned DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst, rdy, flush;
  logic [RB_W-1:0] rob_front;
  logic            s_valid [NSRC];
  logic [RB_W-1:0] s_idx [NSRC];
  logic [XLEN-1:0] s_val [NSRC];
  logic            alu_ready, bru_ready, lsb_ready;
  logic            cdb0_valid, cdb1_valid;
  logic [RB_W-1:0] cdb0_idx, cdb1_idx;
  logic [XLEN-1:0] cdb0_val, cdb1_val;

  always #5 clk = ~clk;

  cdb_wb_arbiter #(
    .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .flush     (flush),
    .rob_front (rob_front),
    .alu_valid (s_valid[0]),
    .alu_idx   (s_idx[0]),
    .alu_val   (s_val[0]),
    .alu_ready (alu_ready),
    .bru_valid (s_valid[1]),
    .bru_idx   (s_idx[1]),
    .bru_val   (s_val[1]),
    .bru_ready (bru_ready),
    .lsb_valid (s_valid[2]),
    .lsb_idx   (s_idx[2]),
    .lsb_val   (s_val[2]),
    .lsb_ready (lsb_ready),
    .cdb0_valid(cdb0_valid),
    .cdb0_idx  (cdb0_idx),
    .cdb0_val  (cdb0_val),
    .cdb1_valid(cdb1_valid),
    .cdb1_idx  (cdb1_idx),
    .cdb1_val  (cdb1_val)
  );

  // Reference model: plain FIFOs per source plus the expected broadcast registers.
  wb_entry_t       mq [NSRC][$];
  logic            m_ready [NSRC];
  logic            m_v0, m_v1;
  wb_entry_t       m_c0, m_c1;
  logic [RB_W-1:0] seen [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NSRC; s++) begin
      mq[s].delete();
      m_ready[s] = 1'b1;
    end
    m_v0 = 1'b0;
    m_v1 = 1'b0;
    m_c0 = '0;
    m_c1 = '0;
  endtask

  function automatic int pick_oldest(input int skip);
    int              b;
    logic [RB_W-1:0] ba, a;
    b  = -1;
    ba = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (s != skip && mq[s].size() != 0) begin
        a = mq[s][0].idx - rob_front;
        if (b < 0 || a < ba) begin
          b  = s;
          ba = a;
        end
      end
    end
    return b;
  endfunction

  task automatic check_outputs();
    check_eq("cdb0_valid", 64'(cdb0_valid), 64'(m_v0));
    check_eq("cdb0_idx", 64'(cdb0_idx), 64'(m_c0.idx));
    check_eq("cdb0_val", 64'(cdb0_val), 64'(m_c0.val));
    check_eq("cdb1_valid", 64'(cdb1_valid), 64'(m_v1));
    check_eq("cdb1_idx", 64'(cdb1_idx), 64'(m_c1.idx));
    check_eq("cdb1_val", 64'(cdb1_val), 64'(m_c1.val));
    check_eq("alu_ready", 64'(alu_ready), 64'(m_ready[0]));
    check_eq("bru_ready", 64'(bru_ready), 64'(m_ready[1]));
    check_eq("lsb_ready", 64'(lsb_ready), 64'(m_ready[2]));
  endtask

  // Advance the model for the current inputs, clock the DUT once and compare.
  task automatic step();
    int   best, second;
    logic acc [NSRC];
    for (int s = 0; s < NSRC; s++) acc[s] = s_valid[s] && m_ready[s] && rdy && !flush;
    if (flush) begin
      for (int s = 0; s < NSRC; s++) begin
        mq[s].delete();
        m_ready[s] = 1'b1;
      end
      m_v0 = 1'b0;
      m_v1 = 1'b0;
    end else if (rdy) begin
      best   = pick_oldest(-1);
      second = pick_oldest(best);
      m_v0   = (best >= 0);
      m_v1   = (second >= 0);
      if (best >= 0) m_c0 = mq[best].pop_front();
      if (second >= 0) m_c1 = mq[second].pop_front();
      for (int s = 0; s < NSRC; s++) begin
        if (acc[s]) mq[s].push_back('{idx: s_idx[s], val: s_val[s]});
        m_ready[s] = (mq[s].size() < DEPTH);
      end
    end
    @(posedge clk);
    #1;
    if (cdb0_valid) seen.push_back(cdb0_idx);
    if (cdb1_valid) seen.push_back(cdb1_idx);
    check_outputs();
  endtask

  task automatic clear_inputs();
    for (int s = 0; s < NSRC; s++) begin
      s_valid[s] = 1'b0;
      s_idx[s]   = '0;
      s_val[s]   = '0;
    end
  endtask

  task automatic drive(input int s, input logic [RB_W-1:0] idx, input logic [XLEN-1:0] val);
    s_valid[s] = 1'b1;
    s_idx[s]   = idx;
    s_val[s]   = val;
  endtask

  initial begin
    logic took;
    int   n;
    rst       = 1'b0;
    rdy       = 1'b1;
    flush     = 1'b0;
    rob_front = '0;
    clear_inputs();
    model_reset();
    #12;
    check_outputs();
    @(negedge clk);
    rst = 1'b1;

    // Single ALU result: visible two edges after acceptance, cdb1 unused.
    drive(0, 4'd3, 32'h11);
    step();
    check_eq("lat_early_valid", 64'(cdb0_valid), 64'd0);
    clear_inputs();
    step();
    check_eq("lat_valid", 64'(cdb0_valid), 64'd1);
    check_eq("lat_idx", 64'(cdb0_idx), 64'd3);
    check_eq("lat_val", 64'(cdb0_val), 64'h11);
    check_eq("lat_cdb1", 64'(cdb1_valid), 64'd0);
    step();

    // Three simultaneous producers, front=2.
    rob_front = 4'd2;
    drive(0, 4'd5, 32'hA5);
    drive(1, 4'd2, 32'hB2);
    drive(2, 4'd4, 32'hC4);
    step();
    clear_inputs();
    step();
    check_eq("tri_cdb0_idx", 64'(cdb0_idx), 64'd2);
    check_eq("tri_cdb1_idx", 64'(cdb1_idx), 64'd4);
    check_eq("tri_cdb1_valid", 64'(cdb1_valid), 64'd1);
    step();
    check_eq("tri_late_idx", 64'(cdb0_idx), 64'd5);
    check_eq("tri_late_cdb1", 64'(cdb1_valid), 64'd0);
    step();

    // Age wrap-around past the end of the ROB.
    rob_front = 4'd14;
    drive(1, 4'd15, 32'hF15);
    drive(2, 4'd1, 32'hF01);
    step();
    clear_inputs();
    step();
    check_eq("wrap_cdb0_idx", 64'(cdb0_idx), 64'd15);
    check_eq("wrap_cdb1_idx", 64'(cdb1_idx), 64'd1);
    step();

    // ALU back-to-back behind older BRU/LSB traffic: backpressure, no loss, age order.
    rob_front = 4'd8;
    seen.delete();
    drive(1, 4'd8, 32'h108);
    drive(2, 4'd10, 32'h210);
    drive(0, 4'd1, 32'h001);
    step();
    drive(1, 4'd9, 32'h109);
    drive(2, 4'd11, 32'h211);
    drive(0, 4'd2, 32'h002);
    step();
    check_eq("bp_alu_ready_low", 64'(alu_ready), 64'd0);
    clear_inputs();
    drive(0, 4'd3, 32'h003);
    took = 1'b0;
    for (int k = 0; k < 10 && !took; k++) begin
      took = alu_ready;
      step();
    end
    check_eq("bp_alu3_accepted", 64'(took), 64'd1);
    clear_inputs();
    repeat (4) step();
    n = 0;
    for (int k = 0; k < seen.size(); k++) begin
      if (seen[k] >= 4'd1 && seen[k] <= 4'd3) begin
        n++;
        check_eq("bp_order", 64'(seen[k]), 64'(n));
      end
    end
    check_eq("bp_count", 64'(n), 64'd3);

    // Flush with four queued entries and a concurrent LSB push.
    rob_front = 4'd0;
    drive(0, 4'd3, 32'h3);
    drive(1, 4'd2, 32'h2);
    drive(2, 4'd1, 32'h1);
    step();
    drive(0, 4'd4, 32'h4);
    drive(1, 4'd5, 32'h5);
    drive(2, 4'd6, 32'h6);
    step();
    clear_inputs();
    flush = 1'b1;
    drive(2, 4'd7, 32'h77);
    step();
    flush = 1'b0;
    clear_inputs();
    check_eq("fl_cdb0_valid", 64'(cdb0_valid), 64'd0);
    check_eq("fl_cdb1_valid", 64'(cdb1_valid), 64'd0);
    check_eq("fl_ready", 64'({alu_ready, bru_ready, lsb_ready}), 64'b111);
    repeat (2) step();
    check_eq("fl_no_ghost", 64'(cdb0_valid), 64'd0);

    // Stall with a broadcast pending.
    drive(0, 4'd1, 32'hA1);
    drive(1, 4'd2, 32'hB2);
    drive(2, 4'd3, 32'hC3);
    step();
    clear_inputs();
    step();
    rdy = 1'b0;
    repeat (3) step();
    check_eq("stall_cdb0_valid", 64'(cdb0_valid), 64'd1);
    check_eq("stall_cdb0_idx", 64'(cdb0_idx), 64'd1);
    check_eq("stall_cdb1_idx", 64'(cdb1_idx), 64'd2);
    rdy = 1'b1;
    step();
    check_eq("resume_idx", 64'(cdb0_idx), 64'd3);
    check_eq("resume_cdb1", 64'(cdb1_valid), 64'd0);
    step();
    check_eq("resume_no_dup", 64'(cdb0_valid), 64'd0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < NSRC; s++) begin
        s_valid[s] = ($urandom_range(0, 99) < 60);
        s_idx[s]   = RB_W'($urandom_range(0, 15));
        s_val[s]   = $urandom;
      end
      rdy   = ($urandom_range(0, 99) < 90);
      flush = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 3) == 0) rob_front = rob_front + 4'd1;
      step();
    end
    flush = 1'b0;
    rdy   = 1'b1;

    // Asynchronous reset in the middle of traffic.
    drive(0, 4'd6, 32'h66);
    drive(1, 4'd7, 32'h77);
    drive(2, 4'd8, 32'h88);
    step();
    clear_inputs();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
